// File: rtl/bcd_prescaler.sv
// rtl/bcd_prescaler.sv - cascaded BCD clock prescaler with tap select and one-shot mode
module bcd_prescaler #(
  parameter int NUM_STAGES = 3,
  parameter int TOP_MOD    = 10,
  parameter int TAP_W      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    clear,
  input  logic                    oneshot,
  input  logic                    start,
  input  logic [TAP_W-1:0]        tap_sel,
  output logic [4*NUM_STAGES-1:0] digits,
  output logic [NUM_STAGES-1:0]   c_enable,
  output logic [NUM_STAGES-1:0]   stage_tc,
  output logic                    tick,
  output logic                    tap_tick,
  output logic                    busy,
  output logic                    done
);

  logic [3:0]            r_digit [NUM_STAGES];
  logic                  r_busy;
  logic                  r_done;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_active;
  logic                  w_load;
  logic [NUM_STAGES-1:0] w_at_max;

  assign w_load   = oneshot & ~r_busy & start;
  assign w_active = run & (~oneshot | r_busy);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      localparam logic [3:0] MAXV = 4'((gi == NUM_STAGES-1) ? TOP_MOD-1 : 9);

      assign w_at_max[gi]     = (r_digit[gi] == MAXV);
      assign stage_tc[gi]     = c_enable[gi] & w_at_max[gi];
      assign digits[4*gi +: 4] = r_digit[gi];

      always_ff @(posedge clk) begin
        if (reset || clear || w_load) begin
          r_digit[gi] <= 4'd0;
        end else if (c_enable[gi]) begin
          r_digit[gi] <= w_at_max[gi] ? 4'd0 : r_digit[gi] + 4'd1;
        end
      end
    end
  endgenerate

  // Each enable is the AND of all lower stages at max, built flat to avoid a comb chain.
  always_comb begin
    c_enable = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      c_enable[i] = w_active;
      for (int j = 0; j < i; j++) begin
        c_enable[i] = c_enable[i] & w_at_max[j];
      end
    end
  end

  assign tick = stage_tc[NUM_STAGES-1];

  always_comb begin
    tap_tick = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (tap_sel == TAP_W'(i)) tap_tick = stage_tc[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    if (clear) begin
      w_busy_nxt = 1'b0;
    end else if (w_load) begin
      w_busy_nxt = 1'b1;
    end else if (!oneshot) begin
      w_busy_nxt = 1'b0;
    end else if (r_busy && tick) begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b1;
    end
  end

  always_comb begin
    busy = r_busy;
    done = r_done;
  end

endmodule

// File: tb/tb_bcd_prescaler.sv
// tb/tb_bcd_prescaler.sv - scoreboard bench for bcd_prescaler, default and (2,6) configurations
module tb_bcd_prescaler;

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  cen;
    logic [7:0]  stc;
    logic        tick;
    logic        tap;
    logic        busy;
    logic        done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, run, clear, oneshot, start;
  logic [2:0] tap_sel;

  logic [11:0] dig_a;
  logic [2:0]  cen_a, stc_a;
  logic        tick_a, tap_a, busy_a, done_a;
  logic [7:0]  dig_b;
  logic [1:0]  cen_b, stc_b;
  logic        tick_b, tap_b, busy_b, done_b;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_cnt [2];
  int m_busy[2];
  int m_done[2];
  int ns_v  [2] = '{3, 2};
  int per_v [2] = '{1000, 60};

  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_prescaler u_dut_a (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .oneshot(oneshot), .start(start),
    .tap_sel(tap_sel), .digits(dig_a), .c_enable(cen_a), .stage_tc(stc_a), .tick(tick_a),
    .tap_tick(tap_a), .busy(busy_a), .done(done_a)
  );

  bcd_prescaler #(.NUM_STAGES(2), .TOP_MOD(6), .TAP_W(3)) u_dut_b (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .oneshot(oneshot), .start(start),
    .tap_sel(tap_sel), .digits(dig_b), .c_enable(cen_b), .stage_tc(stc_b), .tick(tick_b),
    .tap_tick(tap_b), .busy(busy_b), .done(done_b)
  );

  function automatic int pow10(int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic exp_t model_exp(int k);
    exp_t e;
    int   ns, p, cnt, d;
    logic act;
    e   = '0;
    ns  = ns_v[k];
    p   = per_v[k];
    cnt = m_cnt[k];
    act = run && (!oneshot || m_busy[k] != 0);
    for (int i = 0; i < ns; i++) begin
      d = (i == ns-1) ? cnt / pow10(i) : (cnt / pow10(i)) % 10;
      e.digits[4*i +: 4] = d[3:0];
      e.cen[i] = act && ((cnt % pow10(i)) == pow10(i) - 1);
      if (i == ns-1) e.stc[i] = act && (cnt == p - 1);
      else           e.stc[i] = act && ((cnt % pow10(i+1)) == pow10(i+1) - 1);
    end
    e.tick = e.stc[ns-1];
    e.tap  = (int'(tap_sel) < ns) ? e.stc[tap_sel] : 1'b0;
    e.busy = (m_busy[k] != 0);
    e.done = (m_done[k] != 0);
    return e;
  endfunction

  task automatic model_next(int k);
    logic act, tk;
    act = run && (!oneshot || m_busy[k] != 0);
    tk  = act && (m_cnt[k] == per_v[k] - 1);
    if (reset || clear) begin
      m_cnt[k] = 0; m_busy[k] = 0; m_done[k] = 0;
    end else if (oneshot && m_busy[k] == 0 && start) begin
      m_cnt[k] = 0; m_busy[k] = 1; m_done[k] = 0;
    end else begin
      m_done[k] = (oneshot && m_busy[k] != 0 && tk) ? 1 : 0;
      if (act) m_cnt[k] = (m_cnt[k] + 1) % per_v[k];
      if (!oneshot || tk) m_busy[k] = 0;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare(string dut, exp_t o, exp_t e);
    check({dut, ".digits"},   o.digits, e.digits);
    check({dut, ".c_enable"}, 32'(o.cen), 32'(e.cen));
    check({dut, ".stage_tc"}, 32'(o.stc), 32'(e.stc));
    check({dut, ".tick_tap"}, {30'd0, o.tick, o.tap}, {30'd0, e.tick, e.tap});
    check({dut, ".busy_done"}, {30'd0, o.busy, o.done}, {30'd0, e.busy, e.done});
  endtask

  task automatic step(int n);
    exp_t ea, eb, oa, ob;
    for (int c = 0; c < n; c++) begin
      sb.push_back(model_exp(0));
      sb.push_back(model_exp(1));
      @(negedge clk);
      oa = '{digits: 32'(dig_a), cen: 8'(cen_a), stc: 8'(stc_a), tick: tick_a, tap: tap_a,
             busy: busy_a, done: done_a};
      ob = '{digits: 32'(dig_b), cen: 8'(cen_b), stc: 8'(stc_b), tick: tick_b, tap: tap_b,
             busy: busy_b, done: done_b};
      ea = sb.pop_front();
      eb = sb.pop_front();
      compare("A", oa, ea);
      compare("B", ob, eb);
      model_next(0);
      model_next(1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_until_cnt(int target, int budget);
    int n = 0;
    while (m_cnt[0] != target && n < budget) begin
      step(1);
      n++;
    end
    n_cmp++;
    assert (m_cnt[0] == target) else begin
      n_fail++;
      $error("FAIL wait_cnt observed=%0d expected=%0d", m_cnt[0], target);
    end
  endtask

  task automatic run_while_busy(int budget);
    int n = 0;
    while (m_busy[0] != 0 && n < budget) begin
      step(1);
      n++;
    end
    n_cmp++;
    assert (m_busy[0] == 0) else begin
      n_fail++;
      $error("FAIL wait_idle observed=%0d expected=%0d", m_busy[0], 0);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; clear = 1'b0; oneshot = 1'b0; start = 1'b0; tap_sel = 3'd2;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_busy[k] = 0; m_done[k] = 0;
    end
    @(posedge clk);
    #1;
    step(2);
    reset = 1'b0;
    step(2);

    // free run: first tick at 999, then period 1000 (60 for B)
    run = 1'b1;
    step(2100);

    // run toggling halves the rate; digits hold in off cycles
    for (int c = 0; c < 2000; c++) begin
      run = ~run;
      step(1);
    end

    run = 1'b1;
    foreach (tap_sel[b]) begin end
    tap_sel = 3'd0; step(150);
    tap_sel = 3'd1; step(250);
    tap_sel = 3'd3; step(150);
    tap_sel = 3'd7; step(60);
    tap_sel = 3'd2;

    run_until_cnt(537, 1000);
    clear = 1'b1; step(1);
    clear = 1'b0; step(5);

    run_until_cnt(998, 1000);
    reset = 1'b1; step(1);
    reset = 1'b0; step(3);

    // one-shot from nonzero digits
    run_until_cnt(412, 1000);
    run = 1'b0; step(1);
    oneshot = 1'b1; step(3);
    run = 1'b1; step(5);
    start = 1'b1; step(1);
    start = 1'b0; step(500);
    start = 1'b1; step(1);
    start = 1'b0;
    run_while_busy(1000);
    step(20);

    // start on the completing tick is ignored
    start = 1'b1; step(1);
    start = 1'b0;
    run_until_cnt(999, 1000);
    start = 1'b1; step(1);
    start = 1'b0; step(20);

    // pause mid-cycle holds digits and busy
    start = 1'b1; step(1);
    start = 1'b0; step(30);
    run = 1'b0; step(15);
    run = 1'b1; step(10);
    run = 1'b0; step(1);
    oneshot = 1'b0; step(3);
    run = 1'b1; step(30);

    // clear aborts a one-shot cycle without done
    run = 1'b0; step(1);
    oneshot = 1'b1; step(1);
    run = 1'b1; start = 1'b1; step(1);
    start = 1'b0; step(40);
    clear = 1'b1; step(1);
    clear = 1'b0; step(20);
    run = 1'b0; step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_prescaler.md
Name: bcd_prescaler

Overview:
- Parametrised cascade of synchronous modulo-10 (BCD) counter stages clocked from one common clock. Divides the clock by 10^(NUM_STAGES-1)*TOP_MOD.
- Produces per-stage enable and terminal-count pulses, a full-chain tick, and a runtime-selectable tap tick.
- Adds pause (run), synchronous clear, and a one-shot timer mode. Sits between the system timebase and the clock/timer counters that consume a one-cycle enable pulse.

Parameters:
- NUM_STAGES, 3, number of cascaded digit stages (1..8); stage 0 is the fastest.
- TOP_MOD, 10, modulus of stage NUM_STAGES-1 (2..10); all lower stages are modulo 10.
- TAP_W, 3, width of tap_sel; must satisfy 2^TAP_W >= NUM_STAGES.

Ports:
- clk  in  1  common clock; all stages run directly on it, with no derived clocks.
- reset  in  1  synchronous, active-high reset.
- run  in  1  global count enable; 0 pauses the chain with digits held.
- clear  in  1  synchronous clear of digits and one-shot state.
- oneshot  in  1  mode select: 0 = free-run, 1 = one-shot. Change only while run=0.
- start  in  1  arms a one-shot cycle; ignored in free-run mode.
- tap_sel  in  TAP_W  selects which stage_tc bit drives tap_tick.
- digits  out  4*NUM_STAGES  registered BCD digits; digit i is at bits [4i+3:4i].
- c_enable  out  NUM_STAGES  per-stage count enable (c_enable[0] is the fastest).
- stage_tc  out  NUM_STAGES  per-stage terminal-count pulse.
- tick  out  1  full-chain terminal pulse, one cycle wide.
- tap_tick  out  1  equals stage_tc[tap_sel].
- busy  out  1  registered; one-shot cycle in progress.
- done  out  1  registered; one-cycle pulse when a one-shot cycle completes.

Behaviour:
- Reset: digits=0, busy=0, done=0. Combinational outputs follow from these values.
- Priority on each clock edge: reset > clear > start > count.
- active = run & (~oneshot | busy).
- c_enable[0] = active.
- c_enable[i] = c_enable[i-1] & (digit[i-1]==9), for i >= 1.
- All enables, stage_tc, tick and tap_tick are combinational, with zero latency from the digits and run.
- mod_i = 10 for i < NUM_STAGES-1; mod_i = TOP_MOD for the top stage.
- stage_tc[i] = c_enable[i] & (digit[i]==mod_i-1).
- tick = stage_tc[NUM_STAGES-1].
- Digit update: when c_enable[i]=1, the digit goes to 0 if it equals mod_i-1, otherwise it increments. When c_enable[i]=0 the digit holds.
- Digits never leave the range 0..mod_i-1. No other gating is applied.
- Free-run mode: tick fires exactly once every 10^(NUM_STAGES-1)*TOP_MOD cycles in which run=1. The digits wrap to all-zero on the edge after tick. busy=0 and done=0.
- tap_tick: equals stage_tc[tap_sel]. If tap_sel >= NUM_STAGES, tap_tick=0. tap_sel may change at any time; the effect is immediate.
- clear: digits go to 0 and busy goes to 0 on the next edge; done=0. No tick or done is generated by a clear.
- One-shot mode, idle (busy=0): the chain is frozen.
- One-shot mode, start=1 while idle: on the next edge busy goes to 1 and digits are loaded to 0. This applies even if the digits were nonzero.
- One-shot mode, counting: counting proceeds while busy & run. On the edge where tick=1, the digits wrap to 0, busy goes to 0, and done goes to 1 for exactly one cycle.
- start while busy=1 is ignored; there is no retrigger.
- start in the same cycle as the completing tick is also ignored; a new start must be issued in a later cycle.
- Deasserting oneshot forces busy to 0 on the next edge.
- run=0 in the middle of a one-shot cycle holds both the digits and busy.
- Reset or clear in the middle of a cycle aborts it with no done pulse.

Test Plan:
- Defaults, reset then run=1 held → tick first high when digits=999, i.e. in the 1000th cycle after reset release; period then 1000. c_enable[1] high every 10 cycles, c_enable[2] every 100. Digits read 000 on the edge after tick.
- run toggled 1 cycle on, 1 cycle off → tick period 2000 cycles; digits hold in every run=0 cycle. At digits=999 with run=0, tick stays 0.
- tap_sel=0/1/2 → tap_tick period 10/100/1000 cycles. tap_sel=3 → tap_tick stays 0.
- clear asserted at digits=537 → digits=000 next cycle, no tick. Reset asserted at digits=998 → all outputs return to reset values.
- oneshot=1, run=1, pulse start → busy high for exactly 1000 cycles, done high for 1 cycle after tick, then frozen at 000. Second start while busy → no effect. Start at tick cycle → ignored.
- NUM_STAGES=2, TOP_MOD=6 → digit1 counts 0..5 and wraps; tick period 60. tap_sel=2 and tap_sel=3 → tap_tick=0.
